multicycle_control_fsm: RTL

//   Multi-cycle MIPS control unit. Sequences the shared register-file/ALU/data-memory datapath through

---
 rtl/multicycle_control_fsm_if.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit bus: instruction fields and run enable from the fetch side,
// per-state control word, status and retired-instruction count back to it.
//   master : drives en/opcode/funct, observes controls and status
//   slave  : the control FSM
interface multicycle_control_fsm_if #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ALU_OP_W = 4
);
    logic                en;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                IRWrite;
    logic                PCWrite;
    logic                Branch;
    logic                RegWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                MemtoReg;
    logic                ALUSrc;
    logic                RegDst;
    logic                ext_zero;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic                done;
    logic                illegal_instr;
    logic [3:0]          state;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        output en, opcode, funct,
        input  IRWrite, PCWrite, Branch, RegWrite, MemRead, MemWrite, MemtoReg,
               ALUSrc, RegDst, ext_zero, ALU_OP, done, illegal_instr, state, instr_count
    );

    modport slave (
        input  en, opcode, funct,
        output IRWrite, PCWrite, Branch, RegWrite, MemRead, MemWrite, MemtoReg,
               ALUSrc, RegDst, ext_zero, ALU_OP, done, illegal_instr, state, instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit. Steps the shared datapath through
// fetch/decode/execute/memory/writeback one instruction at a time, emits a
// control word per state and counts retired instructions.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.slave  : en/opcode/funct in; control word, done, illegal_instr,
//                state and instr_count out (all registered)
module multicycle_control_fsm #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ALU_OP_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_control_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    typedef struct packed {
        logic                ir_write;
        logic                pc_write;
        logic                branch;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                alu_src;
        logic                reg_dst;
        logic                ext_zero;
        logic [ALU_OP_W-1:0] alu_op;
        logic                done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4'b0001);
    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0010);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b0110);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4'b0111);

    state_t              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [5:0]          funct_q, funct_d;
    logic                illegal_q, illegal_d;
    logic                retire;
    logic [CNT_W-1:0]    cnt_q;
    ctrl_t               ctrl_q, ctrl_d;

    // Post-decode state selected by the live instruction fields.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        s = S_ILLEGAL;
        case (op)
            OP_LW, OP_SW:             s = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI: s = S_I_EXEC;
            OP_BEQ:                   s = S_BRANCH;
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                    fn == FN_OR  || fn == FN_SLT)
                    s = S_R_EXEC;
            end
            default:                  s = S_ILLEGAL;
        endcase
        return s;
    endfunction

    // Control word for a given state and latched instruction fields.
    function automatic ctrl_t ctrl_word(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
            end
            S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE: begin
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
                c.mem_read   = (s == S_MEM_READ) || (s == S_MEM_WB);
                c.mem_to_reg = (s == S_MEM_WB);
                c.reg_write  = (s == S_MEM_WB);
                c.mem_write  = (s == S_MEM_WRITE);
                c.done       = (s == S_MEM_WB) || (s == S_MEM_WRITE);
            end
            S_R_EXEC, S_R_WB: begin
                c.reg_dst = 1'b1;
                case (fn)
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c.alu_op = ALU_ADD;
                endcase
                c.reg_write = (s == S_R_WB);
                c.done      = (s == S_R_WB);
            end
            S_I_EXEC, S_I_WB: begin
                c.alu_src = 1'b1;
                case (op)
                    OP_ANDI: c.alu_op = ALU_AND;
                    OP_ORI:  c.alu_op = ALU_OR;
                    default: c.alu_op = ALU_ADD;
                endcase
                c.ext_zero  = (op == OP_ANDI) || (op == OP_ORI);
                c.reg_write = (s == S_I_WB);
                c.done      = (s == S_I_WB);
            end
            S_BRANCH: begin
                c.alu_op = ALU_SUB;
                c.branch = 1'b1;
                c.done   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next state, field latch and next control word; outputs are registered
    // from the next state so they line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:     state_d = bus.en ? S_FETCH : S_IDLE;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                op_d    = bus.opcode;
                funct_d = bus.funct;
                state_d = decode_next(bus.opcode, bus.funct);
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_I_WB, S_BRANCH: begin
                retire  = 1'b1;
                state_d = bus.en ? S_FETCH : S_IDLE;
            end
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_IDLE;
        endcase
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
        ctrl_d    = ctrl_word(state_d, op_d, funct_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.IRWrite       = ctrl_q.ir_write;
    assign bus.PCWrite       = ctrl_q.pc_write;
    assign bus.Branch        = ctrl_q.branch;
    assign bus.RegWrite      = ctrl_q.reg_write;
    assign bus.MemRead       = ctrl_q.mem_read;
    assign bus.MemWrite      = ctrl_q.mem_write;
    assign bus.MemtoReg      = ctrl_q.mem_to_reg;
    assign bus.ALUSrc        = ctrl_q.alu_src;
    assign bus.RegDst        = ctrl_q.reg_dst;
    assign bus.ext_zero      = ctrl_q.ext_zero;
    assign bus.ALU_OP        = ctrl_q.alu_op;
    assign bus.done          = ctrl_q.done;
    assign bus.illegal_instr = illegal_q;
    assign bus.state         = state_q;
    assign bus.instr_count   = cnt_q;

endmodule
